// File: rtl/entry_timeout_ctrl_pkg.sv
// Shared types and key constants for the keypad-entry controller.
package entry_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE,
    ABORT
  } state_t;

  typedef enum logic [2:0] {
    BUF_NOP,
    BUF_LOAD,
    BUF_PUSH,
    BUF_POP,
    BUF_CLEAR
  } buf_op_t;

  localparam logic [3:0] KEY_BACKSPACE = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;
  localparam logic [3:0] KEY_CANCEL    = 4'hC;
  localparam logic [3:0] DIGIT_MAX     = 4'h9;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/entry_timeout_ctrl_if.sv
// Keypad, timer and code-output signals of entry_timeout_ctrl.
interface entry_timeout_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  key_valid;
  logic [3:0]            key_code;
  logic                  timeout;
  logic                  timer_clear;
  logic [4*DIGITS-1:0]   code_out;
  logic                  code_valid;
  logic                  entry_aborted;
  logic                  entry_busy;
  logic [3:0]            digit_count;

  modport master (
    output key_valid, key_code, timeout,
    input  timer_clear, code_out, code_valid, entry_aborted, entry_busy, digit_count
  );

  modport slave (
    input  key_valid, key_code, timeout,
    output timer_clear, code_out, code_valid, entry_aborted, entry_busy, digit_count
  );
endinterface

// File: rtl/entry_timeout_ctrl_digit_shift_buffer.sv
// Digit buffer: nibble-wide shift register plus digit count.
// Pop (right shift) exists only when ENTRY_BACKSPACE_EN is defined.
module digit_shift_buffer
  import entry_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  buf_op_t             i_op,
  input  logic [3:0]          i_digit,
  output logic [4*DIGITS-1:0] o_buf,
  output logic [3:0]          o_count
);
  localparam int unsigned BUF_W = 4 * DIGITS;

  logic [BUF_W-1:0] r_buf;
  logic [3:0]       r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf   <= '0;
      r_count <= '0;
    end else begin
      case (i_op)
        BUF_LOAD: begin
          r_buf   <= BUF_W'(i_digit);
          r_count <= 4'd1;
        end
        BUF_PUSH: begin
          r_buf   <= (r_buf << 4) | BUF_W'(i_digit);
          r_count <= r_count + 4'd1;
        end
`ifdef ENTRY_BACKSPACE_EN
        BUF_POP: begin
          r_buf   <= r_buf >> 4;
          r_count <= r_count - 4'd1;
        end
`endif
        BUF_CLEAR: begin
          r_buf   <= '0;
          r_count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_buf   = r_buf;
  assign o_count = r_count;

endmodule

// File: rtl/entry_timeout_ctrl.sv
// Keypad-entry controller: collects DIGITS decimal keys, restarts the inactivity
// timer per accepted key, aborts on timeout. Optional backspace: ENTRY_BACKSPACE_EN.
module entry_timeout_ctrl
  import entry_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned KEY_W  = 4
) (
  input logic                  clk,
  input logic                  reset,
  entry_timeout_ctrl_if.slave  bus
);
  state_t               r_state;
  state_t               w_next;
  buf_op_t              w_op;
  logic                 w_clear_pulse;
  logic                 r_timer_clear;
  logic                 r_code_valid;
  logic                 r_entry_aborted;
  logic [4*DIGITS-1:0]  r_code_out;
  logic [4*DIGITS-1:0]  w_buf;
  logic [3:0]           w_count;
  logic [KEY_W-1:0]     w_key;
  logic                 w_key_digit;
  logic                 w_full;
  logic                 w_timeout;

  assign w_key       = bus.key_code;
  assign w_key_digit = bus.key_valid && is_digit(w_key);
  assign w_full      = (w_count == 4'(DIGITS));
  // A raised timer_clear means the timer has not yet dropped its stale flag.
  assign w_timeout   = bus.timeout && !r_timer_clear;

  digit_shift_buffer #(
    .DIGITS (DIGITS)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_op    (w_op),
    .i_digit (w_key),
    .o_buf   (w_buf),
    .o_count (w_count)
  );

  always_comb begin
    w_next        = r_state;
    w_op          = BUF_NOP;
    w_clear_pulse = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_key_digit) begin
          w_op          = BUF_LOAD;
          w_clear_pulse = 1'b1;
          w_next        = COLLECT;
        end
      end
      COLLECT: begin
        if (w_timeout) begin
          w_next = ABORT;
        end else if (bus.key_valid) begin
          if (is_digit(w_key)) begin
            if (!w_full) begin
              w_op          = BUF_PUSH;
              w_clear_pulse = 1'b1;
            end
          end else if (w_key == KEY_ENTER) begin
            w_next = w_full ? DONE : ABORT;
          end else if (w_key == KEY_CANCEL) begin
            w_next = ABORT;
`ifdef ENTRY_BACKSPACE_EN
          end else if (w_key == KEY_BACKSPACE) begin
            if (w_count > 4'd1) begin
              w_op          = BUF_POP;
              w_clear_pulse = 1'b1;
            end else begin
              w_next = ABORT;
            end
`endif
          end
        end
      end
      DONE:  w_next = IDLE;
      ABORT: begin
        w_op   = BUF_CLEAR;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_timer_clear   <= 1'b1;
      r_code_valid    <= 1'b0;
      r_entry_aborted <= 1'b0;
      r_code_out      <= '0;
    end else begin
      r_state         <= w_next;
      r_timer_clear   <= w_clear_pulse;
      r_code_valid    <= (r_state == DONE);
      r_entry_aborted <= (r_state == ABORT);
      if (r_state == DONE) r_code_out <= w_buf;
    end
  end

  assign bus.timer_clear   = r_timer_clear;
  assign bus.code_out      = r_code_out;
  assign bus.code_valid    = r_code_valid;
  assign bus.entry_aborted = r_entry_aborted;
  assign bus.entry_busy    = (r_state == COLLECT);
  assign bus.digit_count   = w_count;

endmodule

// File: tb/tb_entry_timeout_ctrl.sv
// Bench for entry_timeout_ctrl with a 4-edge inactivity timer model and a
// digit-list reference model of the entry rules.
module tb_entry_timeout_ctrl;
  localparam int unsigned D = 4;
  localparam int unsigned W = 4 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_to = 1'b0;
  int unsigned tcnt = 0;
  int checks = 0;
  int failures = 0;

  int n_cv, n_ab, n_tc, max_cnt;
  logic [W-1:0] last_code;

  always #5 clk = ~clk;

  entry_timeout_ctrl_if #(.DIGITS(D)) intf();
  entry_timeout_ctrl #(.DIGITS(D), .KEY_W(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (intf)
  );

  // Timer: flag rises 4 edges after the edge that sees clear, holds until next clear.
  always @(posedge clk) begin
    if (intf.timer_clear) tcnt <= 0;
    else if (tcnt < 4) tcnt <= tcnt + 1;
  end
  always_comb intf.timeout = (tcnt == 4) || force_to;

  // Reference model: list of buffered digits plus a one-cycle pending outcome.
  int m_dig[$];
  bit m_busy = 0;
  int m_pend = 0;
  logic e_tc = 1'b1, e_cv = 1'b0, e_ab = 1'b0, e_busy = 1'b0;
  logic [W-1:0] e_code = '0;
  int e_cnt = 0;

  always @(posedge clk) begin
    bit to_eff;
    bit tc;
    int k;
    k = int'(intf.key_code);
    if (rst) begin
      m_dig.delete();
      m_busy = 0; m_pend = 0;
      e_tc = 1'b1; e_cv = 1'b0; e_ab = 1'b0; e_code = '0;
    end else begin
      to_eff = intf.timeout && !e_tc;
      tc = 0; e_cv = 1'b0; e_ab = 1'b0;
      if (m_pend == 1) begin
        e_cv = 1'b1;
        e_code = '0;
        foreach (m_dig[i]) e_code = (e_code << 4) | W'(m_dig[i]);
        m_pend = 0;
      end else if (m_pend == 2) begin
        e_ab = 1'b1;
        m_dig.delete();
        m_pend = 0;
      end else if (!m_busy) begin
        if (intf.key_valid && k <= 9) begin
          m_dig.delete(); m_dig.push_back(k); m_busy = 1; tc = 1;
        end
      end else if (to_eff) begin
        m_busy = 0; m_pend = 2;
      end else if (intf.key_valid) begin
        if (k <= 9) begin
          if (m_dig.size() < D) begin m_dig.push_back(k); tc = 1; end
        end else if (k == 11) begin
          m_busy = 0; m_pend = (m_dig.size() == D) ? 1 : 2;
        end else if (k == 12) begin
          m_busy = 0; m_pend = 2;
`ifdef ENTRY_BACKSPACE_EN
        end else if (k == 10) begin
          if (m_dig.size() > 1) begin void'(m_dig.pop_back()); tc = 1; end
          else begin m_busy = 0; m_pend = 2; end
`endif
        end
      end
      e_tc = tc;
    end
    e_busy = m_busy;
    e_cnt = m_dig.size();
  end

  task automatic clear_obs();
    n_cv = 0; n_ab = 0; n_tc = 0; max_cnt = 0; last_code = '0;
  endtask

  task automatic step(input logic kv, input logic [3:0] kc);
    intf.key_valid = kv;
    intf.key_code  = kc;
    @(posedge clk);
    @(negedge clk);
    if (intf.code_valid === 1'b1) begin n_cv++; last_code = intf.code_out; end
    if (intf.entry_aborted === 1'b1) n_ab++;
    if (intf.timer_clear === 1'b1) n_tc++;
    if (int'(intf.digit_count) > max_cnt) max_cnt = int'(intf.digit_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++; if (intf.timer_clear !== 1'b1) begin failures++; $display("FAIL reset_tc got=%b exp=1", intf.timer_clear); end
    checks++; if (intf.code_valid !== 1'b0 || intf.entry_aborted !== 1'b0 || intf.entry_busy !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b exp=000", intf.code_valid, intf.entry_aborted, intf.entry_busy); end
    checks++; if (intf.digit_count !== 4'd0 || intf.code_out !== 16'h0) begin failures++; $display("FAIL reset_data got cnt=%0d code=%h exp 0/0000", intf.digit_count, intf.code_out); end
    rst = 1'b0;
    idle(1);
    checks++; if (intf.timer_clear !== 1'b0) begin failures++; $display("FAIL reset_release_tc got=%b exp=0", intf.timer_clear); end
  endtask

  task automatic test_basic();
    clear_obs();
    step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'h3); step(1'b1, 4'h4);
    step(1'b1, 4'hB);
    checks++; if (n_cv != 0) begin failures++; $display("FAIL basic_early_cv got=%0d exp=0", n_cv); end
    idle(1);
    checks++; if (intf.code_valid !== 1'b1 || intf.code_out !== 16'h1234) begin failures++; $display("FAIL basic_latency got cv=%b code=%h exp 1/1234", intf.code_valid, intf.code_out); end
    idle(3);
    checks++; if (n_cv != 1 || last_code !== 16'h1234) begin failures++; $display("FAIL basic_code got n=%0d code=%h exp 1/1234", n_cv, last_code); end
    checks++; if (n_ab != 0) begin failures++; $display("FAIL basic_abort got=%0d exp=0", n_ab); end
    checks++; if (n_tc != 4) begin failures++; $display("FAIL basic_tc_pulses got=%0d exp=4", n_tc); end
  endtask

  task automatic test_timeout_abort();
    clear_obs();
    step(1'b1, 4'h5); step(1'b1, 4'h6);
    checks++; if (intf.digit_count !== 4'd2 || intf.entry_busy !== 1'b1) begin failures++; $display("FAIL to_collect got cnt=%0d busy=%b exp 2/1", intf.digit_count, intf.entry_busy); end
    idle(12);
    checks++; if (n_ab != 1 || n_cv != 0) begin failures++; $display("FAIL to_abort got ab=%0d cv=%0d exp 1/0", n_ab, n_cv); end
    checks++; if (intf.digit_count !== 4'd0 || intf.entry_busy !== 1'b0) begin failures++; $display("FAIL to_cleared got cnt=%0d busy=%b exp 0/0", intf.digit_count, intf.entry_busy); end
    checks++; if (intf.code_out !== 16'h1234) begin failures++; $display("FAIL to_code_hold got=%h exp=1234", intf.code_out); end
  endtask

  task automatic test_short_and_overflow();
    clear_obs();
    step(1'b1, 4'h7); step(1'b1, 4'h8); step(1'b1, 4'h9); step(1'b1, 4'hB);
    idle(3);
    checks++; if (n_ab != 1 || n_cv != 0) begin failures++; $display("FAIL short_enter got ab=%0d cv=%0d exp 1/0", n_ab, n_cv); end
    clear_obs();
    step(1'b1, 4'h4); step(1'b1, 4'h3); step(1'b1, 4'h2); step(1'b1, 4'h1);
    step(1'b1, 4'h5);
    checks++; if (intf.timer_clear !== 1'b0 || intf.digit_count !== 4'd4) begin failures++; $display("FAIL overflow_digit got tc=%b cnt=%0d exp 0/4", intf.timer_clear, intf.digit_count); end
    step(1'b1, 4'hB);
    idle(3);
    checks++; if (n_cv != 1 || last_code !== 16'h4321) begin failures++; $display("FAIL overflow_code got n=%0d code=%h exp 1/4321", n_cv, last_code); end
    checks++; if (n_tc != 4 || n_ab != 0 || max_cnt != 4) begin failures++; $display("FAIL overflow_counts got tc=%0d ab=%0d max=%0d exp 4/0/4", n_tc, n_ab, max_cnt); end
  endtask

  task automatic test_timeout_priority();
    clear_obs();
    step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b0, 4'h0);
    force_to = 1'b1;
    step(1'b1, 4'h3);
    force_to = 1'b0;
    idle(3);
    checks++; if (n_ab != 1 || n_tc != 2) begin failures++; $display("FAIL prio_abort got ab=%0d tc=%0d exp 1/2", n_ab, n_tc); end
    checks++; if (max_cnt != 2 || intf.digit_count !== 4'd0) begin failures++; $display("FAIL prio_nostore got max=%0d cnt=%0d exp 2/0", max_cnt, intf.digit_count); end
    idle(8);
    clear_obs();
    force_to = 1'b1;
    idle(5);
    force_to = 1'b0;
    checks++; if (n_ab != 0 || n_cv != 0 || intf.entry_busy !== 1'b0) begin failures++; $display("FAIL idle_timeout got ab=%0d cv=%0d busy=%b exp 0/0/0", n_ab, n_cv, intf.entry_busy); end
  endtask

  task automatic test_backspace();
    clear_obs();
    step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'hA); step(1'b1, 4'h3); step(1'b1, 4'h4);
`ifdef ENTRY_BACKSPACE_EN
    step(1'b1, 4'h5); step(1'b1, 4'hB);
    idle(3);
    checks++; if (n_cv != 1 || last_code !== 16'h1345 || n_tc != 6) begin failures++; $display("FAIL backspace got n=%0d code=%h tc=%0d exp 1/1345/6", n_cv, last_code, n_tc); end
`else
    step(1'b1, 4'hB);
    idle(3);
    checks++; if (n_cv != 1 || last_code !== 16'h1234 || n_tc != 4) begin failures++; $display("FAIL backspace_off got n=%0d code=%h tc=%0d exp 1/1234/4", n_cv, last_code, n_tc); end
`endif
    checks++; if (n_ab != 0) begin failures++; $display("FAIL backspace_abort got=%0d exp=0", n_ab); end
  endtask

  task automatic test_reset_midentry();
    step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'h3);
    clear_obs();
    rst = 1'b1;
    step(1'b0, 4'h0);
    checks++; if (intf.timer_clear !== 1'b1 || intf.entry_busy !== 1'b0 || intf.digit_count !== 4'd0) begin failures++; $display("FAIL mid_reset got tc=%b busy=%b cnt=%0d exp 1/0/0", intf.timer_clear, intf.entry_busy, intf.digit_count); end
    rst = 1'b0;
    idle(4);
    checks++; if (n_cv != 0 || n_ab != 0) begin failures++; $display("FAIL mid_reset_strobe got cv=%0d ab=%0d exp 0/0", n_cv, n_ab); end
    step(1'b1, 4'h5); step(1'b1, 4'h6); step(1'b1, 4'h7); step(1'b1, 4'h8); step(1'b1, 4'hB);
    clear_obs();
    rst = 1'b1;
    step(1'b0, 4'h0);
    rst = 1'b0;
    step(1'b1, 4'h1); step(1'b1, 4'hC);
    rst = 1'b1;
    step(1'b0, 4'h0);
    rst = 1'b0;
    idle(4);
    checks++; if (n_cv != 0 || n_ab != 0 || intf.code_out !== 16'h0) begin failures++; $display("FAIL reset_done_abort got cv=%0d ab=%0d code=%h exp 0/0/0000", n_cv, n_ab, intf.code_out); end
  endtask

  task automatic test_random();
    logic kv;
    logic [3:0] kc;
    for (int i = 0; i < 1500; i++) begin
      kv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 6) kc = 4'($urandom_range(0, 9));
      else if ($urandom_range(0, 2) == 0) kc = 4'hB;
      else kc = 4'($urandom_range(10, 15));
      force_to = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step(kv, kc);
      checks++; if (intf.timer_clear !== e_tc) begin failures++; $display("FAIL rnd_tc cyc=%0d got=%b exp=%b", i, intf.timer_clear, e_tc); end
      checks++; if (intf.code_valid !== e_cv) begin failures++; $display("FAIL rnd_cv cyc=%0d got=%b exp=%b", i, intf.code_valid, e_cv); end
      checks++; if (intf.entry_aborted !== e_ab) begin failures++; $display("FAIL rnd_ab cyc=%0d got=%b exp=%b", i, intf.entry_aborted, e_ab); end
      checks++; if (intf.entry_busy !== e_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, intf.entry_busy, e_busy); end
      checks++; if (intf.digit_count !== 4'(e_cnt)) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, intf.digit_count, e_cnt); end
      checks++; if (intf.code_out !== e_code) begin failures++; $display("FAIL rnd_code cyc=%0d got=%h exp=%h", i, intf.code_out, e_code); end
    end
    force_to = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    intf.key_valid = 1'b0;
    intf.key_code  = 4'h0;
    clear_obs();
    test_reset();
    test_basic();
    test_timeout_abort();
    test_short_and_overflow();
    test_timeout_priority();
    test_backspace();
    test_reset_midentry();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/entry_timeout_ctrl.md
# entry_timeout_ctrl

Keypad-entry controller for the input/timer/control path. Collects a fixed-length decimal code one key at a time and restarts the inactivity timer on every accepted key by pulsing the timer's `clear`. It consumes the timer's saturating `signal` as `timeout` and aborts a partial entry when `timeout` asserts. Completed codes go downstream with a one-cycle valid strobe.

## Interface
- `DIGITS`, default 4: digits per code; legal range 1..8.
- `KEY_W`, default 4: key code width; fixed at 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid in the same cycle.
- `key_code`  in  4  0x0–0x9 = digit; 0xA = backspace; 0xB = enter; 0xC = cancel; 0xD–0xF are ignored.
- `timeout`  in  1  inactivity flag from the timer; level, high until the next clear.
- `timer_clear`  out  1  drives the timer `clear`; registered one-cycle pulse.
- `code_out`  out  4*DIGITS  last completed code; first digit in the MSB nibble.
- `code_valid`  out  1  one-cycle strobe; `code_out` is valid in that cycle.
- `entry_aborted`  out  1  one-cycle strobe on timeout, cancel, or short enter.
- `entry_busy`  out  1  high in COLLECT.
- `digit_count`  out  4  digits currently buffered.

## Operation
- Reset values:
  - State is IDLE.
  - `timer_clear` = 1; it stays 1 while `reset` is high and drops to 0 on the first cycle after reset releases.
  - All other outputs are 0, and the buffer is zeroed.
- IDLE:
  - `timeout` is ignored.
  - A digit key stores the digit, sets count to 1, pulses `timer_clear` and moves to COLLECT.
  - Non-digit keys are ignored.
- COLLECT:
  - Priority order: `timeout` first, then key handling.
  - `timeout`=1 → ABORT, even if `key_valid` is high in the same cycle.
  - Digit key with count < DIGITS: shift left by 4, insert the digit at the LSB nibble, count+1, pulse `timer_clear`.
  - Digit key with count == DIGITS: ignored; no `timer_clear` pulse.
  - Enter with count == DIGITS → DONE; enter with count < DIGITS → ABORT.
  - Cancel → ABORT.
- DONE, one cycle:
  - Load `code_out` from the buffer and assert `code_valid`.
  - `code_out` holds until the next DONE.
  - Go to IDLE.
- ABORT, one cycle:
  - Assert `entry_aborted`, zero the buffer and count.
  - `code_out` is unchanged.
  - Go to IDLE.
- Keys arriving in DONE or ABORT are dropped.
- Timeout mask: `timeout` is ignored in any cycle where `timer_clear` is 1. This covers the cycle in which the timer is still clearing its stale flag.
- `digit_count` reflects the registered count; it never exceeds DIGITS.

## Timing
- Key accepted at edge N → `timer_clear` high for cycle N+1 only, and `digit_count` updates at N+1.
- Enter accepted at edge N → DONE during cycle N+1 → `code_valid` high at N+2 with `code_out` updated → IDLE at N+2.
- Timeout sampled at edge N → `entry_aborted` high at N+2 → IDLE at N+2.
- Back-to-back keys on consecutive cycles are all accepted; each one produces its own `timer_clear` pulse.
- Synchronous `reset` overrides every state at the next edge, including DONE and ABORT. An interrupted DONE or ABORT emits no strobe.

## Configuration
- `ENTRY_BACKSPACE_EN` defined: in COLLECT, key 0xA with count > 1 shifts the buffer right by 4, decrements count and pulses `timer_clear`. Key 0xA with count == 1 → ABORT.
- `ENTRY_BACKSPACE_EN` undefined: key 0xA is ignored in every state, and no backspace logic is synthesised.

## Structure
- Package `entry_pkg` holds:
  - the state enum (IDLE, COLLECT, DONE, ABORT);
  - key constants `KEY_BACKSPACE`=4'hA, `KEY_ENTER`=4'hB, `KEY_CANCEL`=4'hC;
  - `DIGIT_MAX`=4'h9.
- Sub-module `digit_shift_buffer` contains the 4*DIGITS register, the count, and the push/pop/clear operations. The FSM and `timer_clear` generation stay in the top level.

## Test plan
- Timer model (or the existing timer instance) raises `timeout` 4 edges after `clear`. Keys 1, 2, 3, 4, then enter, one per cycle → `code_valid` one cycle with `code_out`=16'h1234, `entry_aborted`=0, and four `timer_clear` pulses.
- Keys 5, 6, then no further input → `timeout` rises → `entry_aborted` pulses once, `digit_count`=0, `code_out` keeps its previous value.
- Keys 7, 8, 9, then enter → `entry_aborted` pulses, no `code_valid`. Keys 1, 2, 3, 4, 5, enter → the fifth digit is ignored, `code_out`=16'h1234.
- `timeout` and a digit key in the same COLLECT cycle → ABORT, and the digit is not stored. `timeout` high while in IDLE → no strobe.
- With `ENTRY_BACKSPACE_EN`: keys 1, 2, backspace, 3, 4, 5, enter → `code_out`=16'h1345. Without the macro: keys 1, 2, backspace, 3, 4, enter → `code_out`=16'h1234.
- `reset` asserted for one cycle in the middle of COLLECT after 3 digits → next cycle IDLE, `digit_count`=0, `timer_clear`=1 during the reset cycle, and no strobes.
